// File: rtl/rf_operand_fetch.sv
// Register-file operand fetch: selects two operands per accepted request and registers them behind a one-entry skid buffer.
// Optional macro RF_FWD_EN forwards a same-edge register write into the selected operands.
module rf_operand_fetch #(
  parameter int BUS_WIDTH  = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REGS*BUS_WIDTH-1:0] rf_data,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [BUS_WIDTH-1:0]          wr_data,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr_a,
  input  logic [ADDR_WIDTH-1:0]         req_addr_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BUS_WIDTH-1:0]          out_a,
  output logic [BUS_WIDTH-1:0]          out_b
);

  logic                 out_valid_q, out_valid_d;
  logic [BUS_WIDTH-1:0] out_a_q, out_a_d;
  logic [BUS_WIDTH-1:0] out_b_q, out_b_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [BUS_WIDTH-1:0] skid_a_q, skid_a_d;
  logic [BUS_WIDTH-1:0] skid_b_q, skid_b_d;
  logic [BUS_WIDTH-1:0] rd_a, rd_b;
  logic                 accept;

  assign req_ready = !skid_valid_q && !rst;
  assign accept    = req_valid && req_ready;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;

  // Addresses at or beyond NUM_REGS read as zero because no index matches.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr_a == ADDR_WIDTH'(i)) rd_a = rf_data[i*BUS_WIDTH +: BUS_WIDTH];
      if (req_addr_b == ADDR_WIDTH'(i)) rd_b = rf_data[i*BUS_WIDTH +: BUS_WIDTH];
    end
`ifdef RF_FWD_EN
    if (wr_en && wr_addr == req_addr_a) rd_a = wr_data;
    if (wr_en && wr_addr == req_addr_b) rd_b = wr_data;
`endif
  end

`ifndef RF_FWD_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_comb begin
    out_valid_d  = out_valid_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    skid_valid_d = skid_valid_q;
    skid_a_d     = skid_a_q;
    skid_b_d     = skid_b_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_a_d      = skid_a_q;
        out_b_d      = skid_b_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_a_d     = rd_a;
        out_b_d     = rd_b;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output is stalled; the request parks in skid, which drops req_ready next cycle.
      skid_valid_d = 1'b1;
      skid_a_d     = rd_a;
      skid_b_d     = rd_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_a_q     <= '0;
      skid_b_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      skid_valid_q <= skid_valid_d;
      skid_a_q     <= skid_a_d;
      skid_b_q     <= skid_b_d;
    end
  end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed self-checking bench for rf_operand_fetch; a second instance with NUM_REGS=6 covers out-of-range reads.
module tb_rf_operand_fetch;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] rf_data;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_addr_a;
  logic [2:0]   req_addr_b;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_a;
  logic [15:0]  out_b;

  logic         req_ready6;
  logic         out_valid6;
  logic [15:0]  out_a6;
  logic [15:0]  out_b6;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  rf_operand_fetch #(.BUS_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(3)) u_dut (
    .clk(clk), .rst(rst), .rf_data(rf_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b)
  );

  rf_operand_fetch #(.BUS_WIDTH(16), .NUM_REGS(6), .ADDR_WIDTH(3)) u_dut6 (
    .clk(clk), .rst(rst), .rf_data(rf_data[95:0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready6),
    .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .out_valid(out_valid6), .out_ready(out_ready),
    .out_a(out_a6), .out_b(out_b6)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] a, input logic [2:0] b, input logic rdy);
    req_valid  = v;
    req_addr_a = a;
    req_addr_b = b;
    out_ready  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReg(input int idx, input logic [15:0] v);
    rf_data[idx*16 +: 16] = v;
  endtask

  initial begin
    rst     = 1'b1;
    rf_data = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b1);

    // Reset state
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_a", 32'(out_a), 32'd0);
    checkOutput("rst_out_b", 32'(out_b), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Single request
    setReg(3, 16'h1234);
    setReg(5, 16'hBEEF);
    applyStimulus(1'b1, 3'd3, 3'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b1);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_a", 32'(out_a), 32'h1234);
    checkOutput("single_b", 32'(out_b), 32'hBEEF);
    tick();
    checkOutput("single_drained", 32'(out_valid), 32'd0);

    // Same-edge write to the register being read
    setReg(2, 16'h0001);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hA5A5;
    applyStimulus(1'b1, 3'd2, 3'd2, 1'b1);
    tick();
    wr_en = 1'b0;
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b1);
`ifdef RF_FWD_EN
    checkOutput("fwd_a", 32'(out_a), 32'hA5A5);
    checkOutput("fwd_b", 32'(out_b), 32'hA5A5);
`else
    checkOutput("nofwd_a", 32'(out_a), 32'h0001);
    checkOutput("nofwd_b", 32'(out_b), 32'h0001);
`endif
    checkOutput("fwd_valid", 32'(out_valid), 32'd1);
    tick();

    // Backpressure: R1(1,4) to output, R2(4,6) to skid, R3(6,1) held off
    setReg(1, 16'h1111);
    setReg(4, 16'h4444);
    setReg(6, 16'h6666);
    applyStimulus(1'b1, 3'd1, 3'd4, 1'b0);
    checkOutput("bp_ready_r1", 32'(req_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 3'd4, 3'd6, 1'b0);
    checkOutput("bp_ready_r2", 32'(req_ready), 32'd1);
    tick();
    setReg(4, 16'hDEAD);
    applyStimulus(1'b1, 3'd6, 3'd1, 1'b0);
    checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
    tick();
    checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
    checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_hold_a", 32'(out_a), 32'h1111);
    checkOutput("bp_hold_b", 32'(out_b), 32'h4444);
    applyStimulus(1'b1, 3'd6, 3'd1, 1'b1);
    tick();
    checkOutput("bp_r2_a", 32'(out_a), 32'h4444);
    checkOutput("bp_r2_b", 32'(out_b), 32'h6666);
    checkOutput("bp_release_ready", 32'(req_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b1);
    checkOutput("bp_r3_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_r3_a", 32'(out_a), 32'h6666);
    checkOutput("bp_r3_b", 32'(out_b), 32'h1111);
    tick();
    checkOutput("bp_drained", 32'(out_valid), 32'd0);

    // Streaming: reg i holds 0x0101*i
    for (int i = 0; i < 8; i++) setReg(i, 16'(16'h0101 * i));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 3'(7 - i), 1'b1);
      checkOutput($sformatf("stream_ready_%0d", i), 32'(req_ready), 32'd1);
      tick();
      checkOutput($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stream_a_%0d", i), 32'(out_a), 32'(16'h0101 * i));
      checkOutput($sformatf("stream_b_%0d", i), 32'(out_b), 32'(16'h0101 * (7 - i)));
    end
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b1);
    tick();
    checkOutput("stream_drained", 32'(out_valid), 32'd0);

    // Out-of-range on the 6-register instance, in-range on the 8-register one
    applyStimulus(1'b1, 3'd7, 3'd6, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b1);
    checkOutput("oor_valid6", 32'(out_valid6), 32'd1);
    checkOutput("oor_a6", 32'(out_a6), 32'd0);
    checkOutput("oor_b6", 32'(out_b6), 32'd0);
    checkOutput("inr_a8", 32'(out_a), 32'h0707);
    checkOutput("inr_b8", 32'(out_b), 32'h0606);
    tick();

    // Reset while output and skid are both full
    applyStimulus(1'b1, 3'd1, 3'd2, 1'b0);
    tick();
    applyStimulus(1'b1, 3'd3, 3'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0);
    checkOutput("mid_full_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
    checkOutput("mid_rst_a", 32'(out_a), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("mid_post_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b1);
    tick();
    checkOutput("mid_no_emit_1", 32'(out_valid), 32'd0);
    tick();
    checkOutput("mid_no_emit_2", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
